// File: rtl/music_pkg.sv
// Shared constants and types for the music datapath (sequencer, sine reader, codec side).
// Latency: not applicable, package only.
// Backpressure: not applicable, package only.
package music_pkg;

   localparam int STEP_W      = 20;
   localparam int STEP_FRAC_W = 10;
   localparam int SAMPLE_W    = 16;

   // Note indices: 0 is a rest, 1..63 are semitones upward from A0
   localparam int NOTE_REST = 0;
   localparam int NOTE_A4   = 49;

   // Phase step handed to the sine reader: 10 integer bits, 10 fraction bits
   typedef struct packed {
      logic [STEP_W-STEP_FRAC_W-1:0] int_part;
      logic [STEP_FRAC_W-1:0]        frac_part;
   } step_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PLAY = 1'b1
   } np_state_t;

endpackage

// File: rtl/frequency_rom.sv
// 64-entry table of 10.10 phase steps, round(f*2^20/48000) with f = 440*2^((n-49)/12); entry 0 is silence.
// Latency: one cycle; the addressed entry is registered on the cycle load is high.
// Backpressure: none; the registered step holds until the next load.
module frequency_rom
   import music_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [5:0] note,
   output step_t      step_size
);

   logic [STEP_W-1:0] rom_val;

   // Constant table lookup; A4 (index 49) is 9612, i.e. 9 + 396/1024 samples of phase per output sample
   always_comb begin
      rom_val = '0;
      case (note)
         6'd1:  rom_val = 20'd601;
         6'd2:  rom_val = 20'd636;
         6'd3:  rom_val = 20'd674;
         6'd4:  rom_val = 20'd714;
         6'd5:  rom_val = 20'd757;
         6'd6:  rom_val = 20'd802;
         6'd7:  rom_val = 20'd850;
         6'd8:  rom_val = 20'd900;
         6'd9:  rom_val = 20'd954;
         6'd10: rom_val = 20'd1010;
         6'd11: rom_val = 20'd1070;
         6'd12: rom_val = 20'd1134;
         6'd13: rom_val = 20'd1201;
         6'd14: rom_val = 20'd1273;
         6'd15: rom_val = 20'd1349;
         6'd16: rom_val = 20'd1429;
         6'd17: rom_val = 20'd1514;
         6'd18: rom_val = 20'd1604;
         6'd19: rom_val = 20'd1699;
         6'd20: rom_val = 20'd1800;
         6'd21: rom_val = 20'd1907;
         6'd22: rom_val = 20'd2021;
         6'd23: rom_val = 20'd2141;
         6'd24: rom_val = 20'd2268;
         6'd25: rom_val = 20'd2403;
         6'd26: rom_val = 20'd2546;
         6'd27: rom_val = 20'd2697;
         6'd28: rom_val = 20'd2858;
         6'd29: rom_val = 20'd3028;
         6'd30: rom_val = 20'd3208;
         6'd31: rom_val = 20'd3398;
         6'd32: rom_val = 20'd3600;
         6'd33: rom_val = 20'd3815;
         6'd34: rom_val = 20'd4041;
         6'd35: rom_val = 20'd4282;
         6'd36: rom_val = 20'd4536;
         6'd37: rom_val = 20'd4806;
         6'd38: rom_val = 20'd5092;
         6'd39: rom_val = 20'd5395;
         6'd40: rom_val = 20'd5715;
         6'd41: rom_val = 20'd6055;
         6'd42: rom_val = 20'd6415;
         6'd43: rom_val = 20'd6797;
         6'd44: rom_val = 20'd7201;
         6'd45: rom_val = 20'd7629;
         6'd46: rom_val = 20'd8083;
         6'd47: rom_val = 20'd8563;
         6'd48: rom_val = 20'd9072;
         6'd49: rom_val = 20'd9612;
         6'd50: rom_val = 20'd10184;
         6'd51: rom_val = 20'd10789;
         6'd52: rom_val = 20'd11431;
         6'd53: rom_val = 20'd12110;
         6'd54: rom_val = 20'd12830;
         6'd55: rom_val = 20'd13593;
         6'd56: rom_val = 20'd14402;
         6'd57: rom_val = 20'd15258;
         6'd58: rom_val = 20'd16165;
         6'd59: rom_val = 20'd17127;
         6'd60: rom_val = 20'd18145;
         6'd61: rom_val = 20'd19224;
         6'd62: rom_val = 20'd20367;
         6'd63: rom_val = 20'd21578;
         default: rom_val = '0;
      endcase
   end

   // Capture the entry for the newly loaded note; hold it for the life of the note
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         step_size <= '0;
      end else if (load) begin
         step_size <= step_t'(rom_val);
      end
   end

endmodule

// File: rtl/note_player.sv
// Note sequencer: latches a note, supplies its phase step to the sine reader, counts beats, strobes done at note end.
// Latency: step_size 1 cycle after load; sample path 1 cycle; done_with_note in the PLAY cycle where no beats remain.
// Backpressure: none; gen_next_out is gated by play state/enable. Build option NOTE_PLAYER_PAUSE_EN freezes beats while disabled.
module note_player
   import music_pkg::*;
#(
   parameter int NOTE_W = 6,
   parameter int DUR_W  = 6
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic                play_enable,
   input  logic                load_new_note,
   input  logic [NOTE_W-1:0]   note,
   input  logic [DUR_W-1:0]    duration,
   input  logic                beat,
   input  logic                generate_next,
   input  logic                sample_ready,
   input  logic [SAMPLE_W-1:0] sample,
   output logic [STEP_W-1:0]   step_size,
   output logic                gen_next_out,
   output logic [SAMPLE_W-1:0] sample_out,
   output logic                new_sample_ready,
   output logic                done_with_note
);

   np_state_t         state;
   logic [DUR_W-1:0]  cnt;
   logic [NOTE_W-1:0] note_q;
   logic              first_cycle;
   step_t             rom_step;
   logic              beat_en;
   logic              note_end;

   frequency_rom u_frequency_rom (
      .clk       (clk),
      .reset     (reset),
      .load      (load_new_note),
      .note      (note),
      .step_size (rom_step)
   );

`ifdef NOTE_PLAYER_PAUSE_EN
   // Paused notes hold their remaining length until playback resumes
   assign beat_en = beat & play_enable;
`else
   assign beat_en = beat;
`endif

   // A note ends in the first PLAY cycle with no beats left, unless a new load takes over
   assign note_end = (state == ST_PLAY) && (cnt == '0) && !load_new_note;

   assign done_with_note = note_end;
   // The first PLAY cycle is skipped so the sine reader never steps with a stale increment
   assign gen_next_out   = generate_next & (state == ST_PLAY) & play_enable & ~first_cycle;
   assign step_size      = (state == ST_PLAY) ? rom_step : '0;

   // Play/idle sequencing and beat countdown; a load always wins over beats and note end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         note_q      <= '0;
         first_cycle <= 1'b0;
      end else if (load_new_note) begin
         state       <= ST_PLAY;
         cnt         <= duration;
         note_q      <= note;
         first_cycle <= 1'b1;
      end else begin
         first_cycle <= 1'b0;
         if (state == ST_PLAY) begin
            if (cnt == '0) begin
               state <= ST_IDLE;
            end else if (beat_en) begin
               cnt <= cnt - DUR_W'(1);
            end
         end
      end
   end

   // Forward samples during a note, silencing rests; clear the output once idle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sample_out       <= '0;
         new_sample_ready <= 1'b0;
      end else begin
         new_sample_ready <= 1'b0;
         if (sample_ready && (state == ST_PLAY)) begin
            new_sample_ready <= 1'b1;
            sample_out       <= (note_q == NOTE_W'(NOTE_REST)) ? '0 : sample;
         end else if (state == ST_IDLE) begin
            sample_out <= '0;
         end
      end
   end

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: directed scenarios plus random traffic against a behavioural note model.
// Expected samples and done strobes are queued by the driver and popped by a separate monitor.
// Build option NOTE_PLAYER_PAUSE_EN changes how the model treats beats while disabled.
module tb_note_player;
   import music_pkg::*;

   localparam int NOTE_W = 6;
   localparam int DUR_W  = 6;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic                play_enable = 1'b0;
   logic                load_new_note = 1'b0;
   logic [NOTE_W-1:0]   note = '0;
   logic [DUR_W-1:0]    duration = '0;
   logic                beat = 1'b0;
   logic                generate_next = 1'b0;
   logic                sample_ready = 1'b0;
   logic [SAMPLE_W-1:0] sample = '0;
   logic [STEP_W-1:0]   step_size;
   logic                gen_next_out;
   logic [SAMPLE_W-1:0] sample_out;
   logic                new_sample_ready;
   logic                done_with_note;

   always #5 clk = ~clk;

   note_player #(.NOTE_W(NOTE_W), .DUR_W(DUR_W)) dut (
      .clk              (clk),
      .reset            (reset),
      .play_enable      (play_enable),
      .load_new_note    (load_new_note),
      .note             (note),
      .duration         (duration),
      .beat             (beat),
      .generate_next    (generate_next),
      .sample_ready     (sample_ready),
      .sample           (sample),
      .step_size        (step_size),
      .gen_next_out     (gen_next_out),
      .sample_out       (sample_out),
      .new_sample_ready (new_sample_ready),
      .done_with_note   (done_with_note)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int gen_cnt = 0;
   int done_cnt = 0;
   bit mon_en  = 1'b0;

   typedef struct {
      int          cyc;
      logic [15:0] val;
   } sample_exp_t;

   sample_exp_t sq[$];
   int          dq[$];
   int          exp_step = 0;
   bit          exp_gen  = 1'b0;

   // Behavioural note model: is a note sounding, how many beats remain, which pitch, just loaded?
   bit m_play  = 1'b0;
   int m_left  = 0;
   int m_note  = 0;
   bit m_fresh = 1'b0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Equal-tempered pitch converted to a 10.10 phase step at 48 kHz
   function automatic int rom_ref(input int n);
      real f;
      if (n == 0) return 0;
      f = 440.0 * $pow(2.0, (n - 49) / 12.0);
      return $rtoi(f * 1048576.0 / 48000.0 + 0.5);
   endfunction

   // One clock of stimulus: set inputs, record what the DUT owes us, advance the note model
   task automatic drive(input bit ld, input int n, input int d, input bit bt, input bit gn,
                        input bit sr, input logic [15:0] smp, input bit pe);
      sample_exp_t e;
      bit          counts;
      @(posedge clk);
      #1;
      load_new_note = ld;
      note          = NOTE_W'(n);
      duration      = DUR_W'(d);
      beat          = bt;
      generate_next = gn;
      sample_ready  = sr;
      sample        = smp;
      play_enable   = pe;
      exp_step = m_play ? rom_ref(m_note) : 0;
      exp_gen  = gn && m_play && pe && !m_fresh;
      if (m_play && m_left == 0 && !ld) dq.push_back(cyc);
      if (sr && m_play) begin
         e.cyc = cyc + 1;
         e.val = (m_note == 0) ? 16'h0000 : smp;
         sq.push_back(e);
      end
`ifdef NOTE_PLAYER_PAUSE_EN
      counts = bt && pe;
`else
      counts = bt;
`endif
      if (ld) begin
         m_play  = 1'b1;
         m_left  = d;
         m_note  = n;
         m_fresh = 1'b1;
      end else begin
         m_fresh = 1'b0;
         if (m_play) begin
            if (m_left == 0) m_play = 1'b0;
            else if (counts) m_left--;
         end
      end
      mon_en = 1'b1;
   endtask

   task automatic idle(input int cycles, input bit gn);
      for (int i = 0; i < cycles; i++) drive(0, 0, 0, 0, gn, 0, 16'h0, 1);
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   // Monitor: compare every output cycle, popping queued expectations as the DUT presents them
   always @(negedge clk) begin : monitor
      sample_exp_t s;
      int          dc;
      if (mon_en) begin
         check("step_size", step_size, exp_step);
         check("gen_next_out", gen_next_out, exp_gen);
         if (gen_next_out) gen_cnt++;
         if (done_with_note) done_cnt++;
         if (new_sample_ready) begin
            if (sq.size() == 0) check("spurious new_sample_ready", new_sample_ready, 0);
            else begin
               s = sq.pop_front();
               check("sample cycle", cyc, s.cyc);
               check("sample_out", sample_out, s.val);
            end
         end else if (sq.size() != 0 && sq[0].cyc <= cyc) begin
            s = sq.pop_front();
            check("missed new_sample_ready", new_sample_ready, 1);
         end
         if (done_with_note) begin
            if (dq.size() == 0) check("spurious done_with_note", done_with_note, 0);
            else begin
               dc = dq.pop_front();
               check("done cycle", cyc, dc);
            end
         end else if (dq.size() != 0 && dq[0] <= cyc) begin
            dc = dq.pop_front();
            check("missed done_with_note", done_with_note, 1);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, %0d cycles", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, g0;
      // Reset state
      repeat (3) @(negedge clk);
      check("reset step_size", step_size, 0);
      check("reset gen_next_out", gen_next_out, 0);
      check("reset sample_out", sample_out, 0);
      check("reset new_sample_ready", new_sample_ready, 0);
      check("reset done_with_note", done_with_note, 0);
      #1 reset = 1'b1;

      // A4 for three beats
      d0 = done_cnt;
      drive(1, 49, 3, 0, 1, 0, 16'h0, 1);
      drive(0, 0, 0, 0, 1, 1, 16'h4321, 1);
      settle();
      check("A4 step_size", step_size, 9612);
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 1, 1, 0, 16'h0, 1);
         drive(0, 0, 0, 0, 1, 1, 16'($urandom), 1);
      end
      idle(2, 1);
      settle();
      check("A4 done count", done_cnt - d0, 1);
      check("A4 idle step_size", step_size, 0);

      // Lowest note, one beat, pass-through sample
      d0 = done_cnt;
      drive(1, 1, 1, 0, 0, 0, 16'h0, 1);
      drive(0, 0, 0, 0, 0, 1, 16'hBEEF, 1);
      settle();
      check("A0 step_size", step_size, 601);
      drive(0, 0, 0, 1, 1, 0, 16'h0, 1);
      settle();
      check("A0 sample_out", sample_out, 16'hBEEF);
      idle(3, 0);
      settle();
      check("A0 done count", done_cnt - d0, 1);

      // Rest: samples are silenced but still strobed
      d0 = done_cnt;
      drive(1, 0, 2, 0, 0, 0, 16'h0, 1);
      drive(0, 0, 0, 0, 1, 1, 16'h1234, 1);
      drive(0, 0, 0, 0, 0, 0, 16'h0, 1);
      settle();
      check("rest new_sample_ready", new_sample_ready, 1);
      check("rest sample_out", sample_out, 0);
      drive(0, 0, 0, 1, 0, 0, 16'h0, 1);
      drive(0, 0, 0, 1, 0, 0, 16'h0, 1);
      idle(2, 0);
      settle();
      check("rest done count", done_cnt - d0, 1);

      // Zero duration: done straight after load, no sine requests
      d0 = done_cnt;
      g0 = gen_cnt;
      drive(1, 49, 0, 0, 1, 0, 16'h0, 1);
      idle(3, 1);
      settle();
      check("dur0 gen pulses", gen_cnt - g0, 0);
      check("dur0 done count", done_cnt - d0, 1);

      // Reload mid-note with a simultaneous beat
      d0 = done_cnt;
      drive(1, 20, 10, 0, 0, 0, 16'h0, 1);
      drive(0, 0, 0, 1, 1, 0, 16'h0, 1);
      drive(0, 0, 0, 1, 1, 0, 16'h0, 1);
      drive(1, 49, 5, 1, 1, 0, 16'h0, 1);
      drive(0, 0, 0, 0, 1, 0, 16'h0, 1);
      settle();
      check("reload step_size", step_size, 9612);
      for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 1, 0, 16'h0, 1);
      settle();
      check("reload no early done", done_cnt - d0, 0);
      idle(2, 1);
      settle();
      check("reload done count", done_cnt - d0, 1);

      // play_enable low for five beats mid-note
      drive(1, 20, 4, 0, 1, 0, 16'h0, 1);
      drive(0, 0, 0, 1, 1, 0, 16'h0, 1);
      g0 = gen_cnt;
      for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 1, 1, 16'($urandom), 0);
      settle();
      check("paused gen pulses", gen_cnt - g0, 0);
      for (int i = 0; i < 6; i++) drive(0, 0, 0, 1, 1, 0, 16'h0, 1);
      idle(2, 1);

      // Asynchronous reset mid-note
      drive(1, 30, 6, 0, 1, 0, 16'h0, 1);
      drive(0, 0, 0, 0, 1, 1, 16'h7ABC, 1);
      drive(0, 0, 0, 0, 1, 0, 16'h0, 1);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("async reset step_size", step_size, 0);
      check("async reset gen_next_out", gen_next_out, 0);
      check("async reset sample_out", sample_out, 0);
      check("async reset new_sample_ready", new_sample_ready, 0);
      check("async reset done_with_note", done_with_note, 0);
      m_play = 1'b0; m_left = 0; m_note = 0; m_fresh = 1'b0;
      exp_step = 0; exp_gen = 1'b0;
      sq.delete();
      dq.delete();
      @(negedge clk);
      #1 reset = 1'b1;

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         drive($urandom_range(19) == 0, $urandom_range(63), $urandom_range(7),
               $urandom_range(3) == 0, $urandom_range(2) == 0, $urandom_range(2) == 0,
               16'($urandom), $urandom_range(7) != 0);
      end
      for (int i = 0; i < 20; i++) drive(0, 0, 0, 1, 1, 0, 16'h0, 1);
      idle(3, 0);
      settle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/note_player.md
# note_player

Upstream sequencer stage of the music datapath, driving `sine_reader`. It latches one note (pitch index plus duration in beats) and looks up the 10.10 fixed-point `step_size` from an internal frequency ROM. It gates `generate_next` toward `sine_reader` and counts beat strobes until the duration expires, then pulses `done_with_note`. It also registers the returned sample onward to the codec side, forcing silence for rests and idle.

## Interface
- NOTE_W, 6, note index width (0 = rest, 1..63 = A0 upward, semitone steps)
- DUR_W, 6, duration width in beats
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-low
- play_enable  in  1  playback enable
- load_new_note  in  1  single-cycle strobe; latch `note`/`duration`
- note  in  NOTE_W  pitch index
- duration  in  DUR_W  length in beats
- beat  in  1  single-cycle beat strobe (48 per second)
- generate_next  in  1  sample-rate strobe from codec side
- sample_ready  in  1  from `sine_reader`
- sample  in  16  signed sample from `sine_reader`
- step_size  out  20  to `sine_reader`, {integer[19:10], fraction[9:0]}
- gen_next_out  out  1  gated `generate_next` to `sine_reader`
- sample_out  out  16  registered sample to codec side
- new_sample_ready  out  1  one-cycle strobe with `sample_out`
- done_with_note  out  1  one-cycle strobe at note end

## Operation
- FSM states: IDLE, PLAY. Reset → IDLE.
- IDLE→PLAY on `load_new_note`. PLAY→IDLE when beat counter reaches 0, with `done_with_note` = 1 for that one cycle.
- On load (any state), latch `note`, load `cnt = duration`, and fetch ROM[note] into `step_size`.
- ROM entry: round(f·2^20/48000), with f = 440·2^((n−49)/12). Entry 0 = 0.
- `beat` while PLAY and `cnt`≠0: `cnt` decrements. `cnt`=0 in PLAY: go to IDLE and assert `done_with_note`.
- `duration` = 0: note ends on the cycle after load; no samples are passed.
- Load and beat in the same cycle: load wins, beat dropped. Load while `done_with_note` would fire: load wins, no done pulse.
- `gen_next_out = generate_next & (state==PLAY) & play_enable`.
- On `sample_ready` in PLAY, `sample_out <= (note==0) ? 0 : sample` and `new_sample_ready` pulses. In IDLE, `sample_out` is 0.
- `step_size` is forced to 0 in IDLE.

## Timing
- Reset values: `step_size` 0, `gen_next_out` 0, `sample_out` 0, `new_sample_ready` 0, `done_with_note` 0, state IDLE, `cnt` 0.
- ROM is synchronous: `step_size` is valid 1 cycle after `load_new_note`. `gen_next_out` is suppressed on that cycle.
- Sample path latency is 1 cycle: `sample_ready` at cycle t gives `new_sample_ready`/`sample_out` at t+1.
- `done_with_note` fires 1 cycle after the beat that brings `cnt` to 0.
- Reset mid-note returns to IDLE immediately, and all outputs go to 0 asynchronously.

## Configuration
- `NOTE_PLAYER_PAUSE_EN` defined: `play_enable` low freezes `cnt`, so beats are ignored, and `gen_next_out` is 0. The note resumes on re-enable.
- `NOTE_PLAYER_PAUSE_EN` undefined: `play_enable` only gates `gen_next_out`, and `cnt` keeps counting beats.

## Structure
- Shared package `music_pkg` holds:
  - `STEP_W` = 20 and `SAMPLE_W` = 16;
  - note index constants `NOTE_REST` = 0 and `NOTE_A4` = 49;
  - typedef for the 10.10 step.
- One sub-module: `frequency_rom`, 64×20 synchronous ROM, address `note`, output `step_size`.
- FSM, beat counter and sample register live in `note_player`.

## Test plan
- Reset low, then load note 49, duration 3 → `step_size` = 9612 ({10'd9,10'd396}) one cycle later. After the third `beat`, `done_with_note` pulses once and `step_size` returns to 0.
- Load note 1, duration 1 → `step_size` = 601. One beat → done one cycle later.
- Load note 0 (rest), duration 2, drive `sample_ready` with `sample` = 16'h1234 → `sample_out` = 0 and `new_sample_ready` pulses; done after 2 beats.
- Load with duration 0 → `done_with_note` the cycle after load, no `gen_next_out` pulses.
- Load note 49 while a note 20 is mid-duration, with `beat` in the same cycle → `cnt` = new duration, no done pulse, `step_size` switches to 9612.
- With `NOTE_PLAYER_PAUSE_EN`, drop `play_enable` for 5 beats mid-note → `cnt` unchanged, `gen_next_out` = 0. Assert reset mid-note → all outputs 0 immediately.
